lc3b_scoreboard: RTL and testbench

- Decode-side issue gate that consumes the decoded control word fields (sr1use, sr2use, load_regfile, load_cc, destination) and register numbers for the instruction in ID.
- Tracks in-flight writes to R0-R7 and the condition codes using per-register pending counters.
- Raises stall on RAW or CC hazards and when a counter is saturated.
- Counters increment on issue into EX and decrement on writeback retirement.

---
 rtl/lc3b_scoreboard.sv | 135 +++++++++++++
 tb/tb_lc3b_scoreboard.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_scoreboard.sv
// Decode-side issue gate: per-register and CC pending-write counters produce RAW/CC/saturation stalls.
// Optional macro WB_BYPASS_EN lets a same-cycle final retirement release a waiting reader.
module lc3b_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREGS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic [2:0]       id_dest,
  input  logic             id_sr1use,
  input  logic             id_sr2use,
  input  logic             id_load_regfile,
  input  logic             id_load_cc,
  input  logic             id_is_br,
  input  logic             ex_ready,
  input  logic             wb_valid,
  input  logic [2:0]       wb_dest,
  input  logic             wb_load_regfile,
  input  logic             wb_load_cc,
  input  logic             flush,
  output logic             stall,
  output logic             issue,
  output logic [NREGS-1:0] pending_mask,
  output logic             cc_pending,
  output logic             busy,
  output logic             sb_error
);

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  logic [NREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]            cc_cnt_q, cc_cnt_d;
  logic                        sb_error_q, sb_error_d;

  logic [NREGS-1:0] dec_r, inc_r, hz_r;
  logic             cc_dec, cc_inc, cc_hz;
  logic             raw1, raw2, cch, satr, satc;

  // Returns {error, next_count}; error flags an underflow or overflow attempt.
  function automatic logic [CNT_W:0] cnt_upd(input logic [CNT_W-1:0] c,
                                             input logic inc, input logic dec);
    logic [CNT_W:0] res;
    res = {1'b0, c};
    if (inc && !dec) begin
      if (c == MAX) res = {1'b1, c};
      else          res = {1'b0, c + 1'b1};
    end else if (dec && !inc) begin
      if (c == '0)  res = {1'b1, c};
      else          res = {1'b0, c - 1'b1};
    end
    return res;
  endfunction

  always_comb begin
    dec_r = '0;
    hz_r  = '0;
    raw1  = 1'b0;
    raw2  = 1'b0;
    satr  = 1'b0;
    for (int r = 0; r < NREGS; r++) begin
      dec_r[r] = wb_valid & wb_load_regfile & (wb_dest == 3'(r));
      hz_r[r]  = (cnt_q[r] != '0);
`ifdef WB_BYPASS_EN
      // Regfile writes before it is read, so the last outstanding write retiring now is safe.
      if (cnt_q[r] == CNT_W'(1) && dec_r[r]) hz_r[r] = 1'b0;
`endif
      if (id_sr1use && id_sr1 == 3'(r) && hz_r[r]) raw1 = 1'b1;
      if (id_sr2use && id_sr2 == 3'(r) && hz_r[r]) raw2 = 1'b1;
      if (id_load_regfile && id_dest == 3'(r) && cnt_q[r] == MAX) satr = 1'b1;
    end
    cc_dec = wb_valid & wb_load_cc;
    cc_hz  = (cc_cnt_q != '0);
`ifdef WB_BYPASS_EN
    if (cc_cnt_q == CNT_W'(1) && cc_dec) cc_hz = 1'b0;
`endif
    cch  = id_is_br & cc_hz;
    satc = id_load_cc & (cc_cnt_q == MAX);
  end

  assign stall = id_valid & (raw1 | raw2 | cch | satr | satc);
  assign issue = id_valid & ex_ready & ~stall;

  always_comb begin
    logic [CNT_W:0] u;
    logic           err;
    inc_r      = '0;
    cnt_d      = cnt_q;
    cc_cnt_d   = cc_cnt_q;
    sb_error_d = sb_error_q;
    err        = 1'b0;
    u          = '0;
    cc_inc     = issue & id_load_cc;
    for (int r = 0; r < NREGS; r++) begin
      inc_r[r] = issue & id_load_regfile & (id_dest == 3'(r));
      u        = cnt_upd(cnt_q[r], inc_r[r], dec_r[r]);
      cnt_d[r] = u[CNT_W-1:0];
      err      = err | u[CNT_W];
    end
    u        = cnt_upd(cc_cnt_q, cc_inc, cc_dec);
    cc_cnt_d = u[CNT_W-1:0];
    err      = err | u[CNT_W];
    // Flush squashes everything younger than WB, so any WB retirement is simply absorbed.
    if (flush) begin
      cnt_d    = '0;
      cc_cnt_d = '0;
    end else begin
      sb_error_d = sb_error_q | err;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      cc_cnt_q   <= '0;
      sb_error_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cc_cnt_q   <= cc_cnt_d;
      sb_error_q <= sb_error_d;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int r = 0; r < NREGS; r++) pending_mask[r] = (cnt_q[r] != '0);
  end

  assign cc_pending = (cc_cnt_q != '0);
  assign busy       = (|pending_mask) | cc_pending;
  assign sb_error   = sb_error_q;

endmodule

// File: tb/tb_lc3b_scoreboard.sv
// Directed-vector bench for lc3b_scoreboard; expected values are hand-computed per step.
module tb_lc3b_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_sr1use, id_sr2use, id_load_regfile, id_load_cc, id_is_br;
  logic [2:0] id_sr1, id_sr2, id_dest, wb_dest;
  logic       ex_ready, wb_valid, wb_load_regfile, wb_load_cc, flush;
  logic       stall, issue, cc_pending, busy, sb_error;
  logic [7:0] pending_mask;

  int vectors = 0;
  int miscompares = 0;

`ifdef WB_BYPASS_EN
  localparam logic BYP_STALL = 1'b0;
`else
  localparam logic BYP_STALL = 1'b1;
`endif

  lc3b_scoreboard #(.CNT_W(2), .NREGS(8)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2), .id_dest(id_dest),
    .id_sr1use(id_sr1use), .id_sr2use(id_sr2use),
    .id_load_regfile(id_load_regfile), .id_load_cc(id_load_cc), .id_is_br(id_is_br),
    .ex_ready(ex_ready),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .wb_load_regfile(wb_load_regfile), .wb_load_cc(wb_load_cc),
    .flush(flush),
    .stall(stall), .issue(issue), .pending_mask(pending_mask),
    .cc_pending(cc_pending), .busy(busy), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [2:0] s1, input logic u1,
                        input logic [2:0] s2, input logic u2, input logic [2:0] d,
                        input logic lr, input logic lcc, input logic br);
    id_valid = v; id_sr1 = s1; id_sr1use = u1; id_sr2 = s2; id_sr2use = u2;
    id_dest = d; id_load_regfile = lr; id_load_cc = lcc; id_is_br = br;
  endtask

  task automatic set_wb(input logic v, input logic [2:0] d, input logic lr, input logic lcc);
    wb_valid = v; wb_dest = d; wb_load_regfile = lr; wb_load_cc = lcc;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 0, 0);
    flush = 1'b0;
    ex_ready = 1'b1;
  endtask

  // Advance to just after the next rising edge, then let combinational outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    #1;
    check_vec("reset_pending", pending_mask, 8'h00);
    check_vec("reset_busy", busy, 1'b0);
    check_vec("reset_stall", stall, 1'b0);
    check_vec("reset_sberr", sb_error, 1'b0);
    #2 reset = 1'b0;
    tick();

    // RAW on R3
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0); #1;
    check_vec("raw_first_issue", issue, 1'b1);
    tick();
    check_vec("raw_pend_r3", pending_mask, 8'h08);
    set_id(1, 3, 1, 2, 1, 1, 1, 0, 0); #1;
    check_vec("raw_stall", stall, 1'b1);
    check_vec("raw_issue_blocked", issue, 1'b0);
    ex_ready = 1'b0;
    set_wb(1, 3, 1, 0); #1;
    check_vec("raw_stall_on_retire", stall, BYP_STALL);
    tick();
    ex_ready = 1'b1;
    set_wb(0, 0, 0, 0); #1;
    check_vec("raw_pend_clear", pending_mask, 8'h00);
    check_vec("raw_released", stall, 1'b0);
    check_vec("raw_reader_issue", issue, 1'b1);
    tick();
    check_vec("raw_pend_r1", pending_mask, 8'h02);
    idle();
    set_wb(1, 1, 1, 0);
    tick();
    check_vec("raw_drained", busy, 1'b0);

    // CC hazard
    idle();
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    check_vec("cc_pending_set", cc_pending, 1'b1);
    check_vec("cc_busy", busy, 1'b1);
    set_id(1, 0, 0, 0, 0, 0, 0, 0, 1); #1;
    check_vec("cc_br_stall", stall, 1'b1);
    tick();
    check_vec("cc_br_stall_hold", stall, 1'b1);
    ex_ready = 1'b0;
    set_wb(1, 0, 0, 1); #1;
    check_vec("cc_stall_on_retire", stall, BYP_STALL);
    tick();
    ex_ready = 1'b1;
    set_wb(0, 0, 0, 0); #1;
    check_vec("cc_pending_clear", cc_pending, 1'b0);
    check_vec("cc_br_issue", issue, 1'b1);
    tick();
    idle(); #1;
    check_vec("cc_idle_busy", busy, 1'b0);

    // Simultaneous inc/dec on R7
    set_id(1, 0, 0, 0, 0, 7, 1, 0, 0);
    tick();
    check_vec("sim_pend_r7", pending_mask, 8'h80);
    set_wb(1, 7, 1, 0); #1;
    check_vec("sim_issue", issue, 1'b1);
    tick();
    check_vec("sim_pend_r7_kept", pending_mask, 8'h80);
    idle();
    set_wb(1, 7, 1, 0);
    tick();
    check_vec("sim_pend_r7_clear", pending_mask, 8'h00);
    check_vec("sim_no_error", sb_error, 1'b0);

    // Saturation on R5
    idle();
    set_id(1, 0, 0, 0, 0, 5, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_vec($sformatf("sat_issue_%0d", i), issue, 1'b1);
      tick();
    end
    check_vec("sat_pend_r5", pending_mask, 8'h20);
    check_vec("sat_fourth_stall", stall, 1'b1);
    check_vec("sat_fourth_blocked", issue, 1'b0);
    set_wb(1, 5, 1, 0); #1;
    check_vec("sat_not_masked", stall, 1'b1);
    tick();
    set_wb(0, 0, 0, 0); #1;
    check_vec("sat_writer_go", issue, 1'b1);
    tick();
    check_vec("sat_full_again", stall, 1'b1);
    check_vec("sat_no_error", sb_error, 1'b0);

    // Flush clears R5, then set up R2=1, CC=2
    idle();
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    check_vec("flush1_busy", busy, 1'b0);
    set_id(1, 0, 0, 0, 0, 2, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    idle(); #1;
    check_vec("pre_flush_pend", pending_mask, 8'h04);
    check_vec("pre_flush_cc", cc_pending, 1'b1);
    flush = 1'b1;
    set_wb(1, 2, 1, 0);
    tick();
    idle(); #1;
    check_vec("flush_pend", pending_mask, 8'h00);
    check_vec("flush_cc", cc_pending, 1'b0);
    check_vec("flush_busy", busy, 1'b0);
    check_vec("flush_sberr", sb_error, 1'b0);
    set_wb(1, 2, 1, 0);
    tick();
    idle(); #1;
    check_vec("underflow_sberr", sb_error, 1'b1);
    check_vec("underflow_pend", pending_mask, 8'h00);
    tick();
    check_vec("sberr_sticky", sb_error, 1'b1);

    // Asynchronous reset mid-run with cnt[R3]=2
    set_id(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    tick();
    set_id(1, 3, 1, 0, 0, 4, 1, 0, 0); #1;
    check_vec("pre_reset_pend", pending_mask, 8'h08);
    check_vec("pre_reset_stall", stall, 1'b1);
    #1 reset = 1'b1;
    #1;
    check_vec("async_reset_pend", pending_mask, 8'h00);
    check_vec("async_reset_busy", busy, 1'b0);
    check_vec("async_reset_stall", stall, 1'b0);
    check_vec("async_reset_sberr", sb_error, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
